conv1d_k3_engine: RTL
=====================

CONV1D_K3_ENGINE -- requirements
Module: conv1d_k3_engine

Interface
REQ-001 Parameter DW, 16, signed data/weight word width.
REQ-002 Parameter LINE_LEN, 10, words per input line.
REQ-003 Parameter SHIFT, 8, arithmetic right shift applied to the accumulator before saturation.
REQ-004 Parameter RELU, 0, when 1 negative results are clamped to 0.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to process one line; sampled only in IDLE.
REQ-008 w_in  input  3*DW  kernel taps, signed; bits [3*DW-1:2*DW] = w0, [2*DW-1:DW] = w1, [DW-1:0] = w2.
REQ-009 mem_rd_en  output  1  read enable to the upstream line memory.
REQ-010 line_in  input  LINE_LEN*DW  line from the line memory, combinational; most-significant word = element 0, least-significant word = element LINE_LEN-1.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 out_data  output  DW  signed result word.
REQ-013 out_valid  output  1  one-cycle qualifier for out_data/out_idx.
REQ-014 out_idx  output  4  output position n, 0..LINE_LEN-3.
REQ-015 done  output  1  one-cycle pulse after the last output of a line.

Function
REQ-016 The block SHALL compute y[n] = sat(shift(w0*x[n] + w1*x[n+1] + w2*x[n+2])) for n = 0..LINE_LEN-3 (8 outputs at default), all operands signed.
REQ-017 The block SHALL use one DW x DW signed multiplier and a 2*DW+2 bit signed accumulator; no intermediate overflow is permitted.
REQ-018 shift SHALL be an arithmetic right shift by SHIFT (round toward minus infinity); sat SHALL clamp to [-2^(DW-1), 2^(DW-1)-1], then apply RELU clamp when RELU=1.
REQ-019 FSM states SHALL be IDLE, LOAD, MAC, OUT, DONE.
REQ-020 IDLE: on start=1, capture w_in into internal tap registers, clear n, go to LOAD.
REQ-021 LOAD: drive mem_rd_en=1 for exactly this one cycle, capture line_in into an internal line buffer at the clock edge, go to MAC.
REQ-022 MAC: three cycles, tap index k = 0,1,2; accumulator cleared at k=0 then accumulates w_k*x[n+k]; after k=2 go to OUT.
REQ-023 OUT: one cycle with out_valid=1, out_data=y[n], out_idx=n; if n = LINE_LEN-3 go to DONE, else n+1 and MAC.
REQ-024 DONE: done=1 for one cycle, go to IDLE; next start is accepted the following cycle.
REQ-025 Latency: start sampled at cycle 0 -> LOAD cycle 1 -> y[n] valid at cycle 5+4n -> y[7] at cycle 33 -> done at cycle 34 (defaults).
REQ-026 start asserted in any state other than IDLE SHALL be ignored, with no effect on taps, line buffer or sequence.
REQ-027 Changes on line_in or w_in after their capture cycle SHALL NOT affect the running line.
REQ-028 mem_rd_en, out_valid and done SHALL be registered-state decodes, never high outside LOAD, OUT and DONE respectively.
REQ-029 out_data and out_idx SHALL hold their last value outside OUT; consumers use out_valid only.

Reset
REQ-030 On reset low, state SHALL go to IDLE immediately; busy, mem_rd_en, out_valid, done = 0; out_data, out_idx, n, k, accumulator, taps, line buffer = 0.
REQ-031 Reset asserted mid-line SHALL abort the line with no further out_valid or done; the first start after release SHALL run a complete fresh line.

Verification
REQ-032 Identity: x[i]=256*i, w0=256, w1=w2=0 -> out_valid at cycles 5,9,...,33 with out_data 0,256,...,1792, out_idx 0..7, done at cycle 34, mem_rd_en high only at cycle 1.
REQ-033 Positive saturation: all x=0x7FFF, all w=0x7FFF -> every out_data = 0x7FFF (32767).
REQ-034 Negative/ReLU: all x=-256, all w=256 -> out_data = -768 (0xFD00) with RELU=0; 0 with RELU=1; all x=0x8000, w0=0x7FFF, w1=w2=0 -> -32768 with RELU=0.
REQ-035 Start while busy: second start pulse at cycle 10 and line_in changed at cycle 10 -> sequence, outputs and done timing identical to REQ-032.
REQ-036 Reset mid-line: reset low at cycle 15 -> all outputs 0 at once, no done; release, start -> full REQ-032 sequence from cycle 0 relative to new start.

Source files
------------

// File: rtl/conv1d_k3_engine.sv
// Three-tap signed 1-D convolution over one captured line, using a single shared
// multiplier over three MAC cycles per output, with arithmetic shift, saturation and optional ReLU.
module conv1d_k3_engine #(
    parameter int DW       = 16,
    parameter int LINE_LEN = 10,
    parameter int SHIFT    = 8,
    parameter int RELU     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3*DW-1:0]            w_in,
    output logic                       mem_rd_en,
    input  logic [LINE_LEN*DW-1:0]     line_in,
    output logic                       busy,
    output logic signed [DW-1:0]       out_data,
    output logic                       out_valid,
    output logic [3:0]                 out_idx,
    output logic                       done
);

    localparam int AW = 2*DW + 2;
    localparam logic [3:0] LAST_N = 4'(LINE_LEN - 3);
    localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             n_q, n_d;
    logic [1:0]             k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [DW-1:0]   w_q [0:2];
    logic signed [DW-1:0]   w_d [0:2];
    logic signed [DW-1:0]   x_q [0:LINE_LEN-1];
    logic signed [DW-1:0]   x_d [0:LINE_LEN-1];
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic [3:0]             out_idx_q, out_idx_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q, done_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic                   busy_q, busy_d;

    logic [3:0]             x_idx_s;
    logic signed [DW-1:0]   w_sel_s;
    logic signed [DW-1:0]   x_sel_s;
    logic signed [2*DW-1:0] prod_s;

    // Floor shift (>>> on signed), clamp to DW bits, then optional ReLU.
    function automatic logic signed [DW-1:0] sat_fn(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        logic signed [DW-1:0] r;
        s = a >>> SHIFT;
        if (s > MAX_V) begin
            r = MAX_V[DW-1:0];
        end else if (s < MIN_V) begin
            r = MIN_V[DW-1:0];
        end else begin
            r = s[DW-1:0];
        end
        if ((RELU == 1) && r[DW-1]) begin
            r = {DW{1'b0}};
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Shared multiplier operand selection for tap k at output position n.
    always_comb begin
        x_idx_s = n_q + 4'(k_q);
        w_sel_s = w_q[k_q];
        x_sel_s = x_q[x_idx_s];
        prod_s  = w_sel_s * x_sel_s;
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        w_d        = w_q;
        x_d        = x_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d[0]  = w_in[3*DW-1:2*DW];
                    w_d[1]  = w_in[2*DW-1:DW];
                    w_d[2]  = w_in[DW-1:0];
                    n_d     = 4'd0;
                    k_d     = 2'd0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < LINE_LEN; i++) begin
                    x_d[i] = line_in[(LINE_LEN-1-i)*DW +: DW];
                end
                k_d     = 2'd0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = (k_q == 2'd0) ? AW'(prod_s) : acc_q + AW'(prod_s);
                if (k_q == 2'd2) begin
                    // Result registered here so it is already stable throughout OUT.
                    out_data_d = sat_fn(acc_d);
                    out_idx_d  = n_q;
                    k_d        = 2'd0;
                    state_d    = S_OUT;
                end else begin
                    k_d        = k_q + 2'd1;
                    state_d    = S_MAC;
                end
            end
            S_OUT: begin
                if (n_q == LAST_N) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 4'd1;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        mem_rd_en_d = (state_d == S_LOAD);
        out_valid_d = (state_d == S_OUT);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            n_q         <= 4'd0;
            k_q         <= 2'd0;
            acc_q       <= {AW{1'b0}};
            for (int i = 0; i < 3; i++) begin
                w_q[i] <= {DW{1'b0}};
            end
            for (int i = 0; i < LINE_LEN; i++) begin
                x_q[i] <= {DW{1'b0}};
            end
            out_data_q  <= {DW{1'b0}};
            out_idx_q   <= 4'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
            x_q         <= x_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

endmodule
